// File: rtl/wbu_pkg.sv
// wbu_pkg: shared definitions for the write-back unit.
//   WR_SRC_*    : encodings of the GPR write-data source select
//   wbu_state_t : occupancy of the head/skid buffer
//   wbu_entry_t : buffered result layout at the default widths
package wbu_pkg;

  localparam int WBU_DATA_W   = 64;
  localparam int WBU_ADDR_W   = 32;
  localparam int WBU_GPR_ID_W = 5;

  // Code 3 is reserved and decodes as ALU.
  localparam logic [1:0] WR_SRC_ALU = 2'd0;
  localparam logic [1:0] WR_SRC_LSU = 2'd1;
  localparam logic [1:0] WR_SRC_PC4 = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } wbu_state_t;

  typedef struct packed {
    logic [WBU_ADDR_W-1:0]   pc;
    logic                    wr_en;
    logic [WBU_GPR_ID_W-1:0] wr_id;
    logic [WBU_DATA_W-1:0]   wr_data;
  } wbu_entry_t;

endpackage

// File: rtl/wbu_skid_buf.sv
// wbu_skid_buf: two-entry head/skid buffer with valid/ready on both sides.
//   clk, rst_n : clock, synchronous active-low reset
//   flush      : drop every buffered entry (takes priority over push)
//   in_vld     : upstream offers in_data
//   in_rdy     : buffer can take an entry (registered-state decode only)
//   in_data    : entry to capture
//   out_vld    : head entry is valid
//   out_rdy    : downstream consumes the head this cycle
//   head       : current head entry, stable until consumed
module wbu_skid_buf
  import wbu_pkg::*;
#(
  parameter type entry_t = wbu_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   in_vld,
  output logic   in_rdy,
  input  entry_t in_data,
  output logic   out_vld,
  input  logic   out_rdy,
  output entry_t head
);

  wbu_state_t state;
  entry_t     skid;
  logic       push, pop;

  assign in_rdy  = (state != TWO);
  assign out_vld = (state != EMPTY);
  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else if (flush) begin
      // A pop in this cycle still completes downstream; only the state drops.
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (push) begin
          head  <= in_data;
          state <= ONE;
        end
        ONE: begin
          if (push && pop) begin
            head <= in_data;          // head retires, newcomer takes its place
          end else if (push) begin
            skid  <= in_data;         // head must stay stable: park in skid
            state <= TWO;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: if (pop) begin
          head  <= skid;
          state <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/wbu.sv
// wbu: write-back unit downstream of the LSU.
//   i_sys_clk, i_sys_rst_n : clock, synchronous active-low reset
//   i_sys_flush            : discard all buffered results
//   i_lsu_valid/o_wbu_ready: upstream result handshake
//   i_idu_ctr_reg_wr_*     : GPR write enable and data-source select
//   i_idu_gpr_wr_id        : destination register
//   i_exu_res, i_lsu_gpr_wr_data, i_ifu_pc : candidate write-data sources
//   i_cmt_ready            : commit side accepts the head retire
//   o_wbu_valid, o_wbu_pc  : head entry status
//   o_wbu_gpr_wr_*         : GPR write port, strobed on retire
//   o_wbu_fwd_*            : forwarding tap for hazard logic
//   o_wbu_retire_cnt       : instructions retired since reset
module wbu
  import wbu_pkg::*;
#(
  parameter int DATA_WIDTH   = WBU_DATA_W,
  parameter int ADDR_WIDTH   = WBU_ADDR_W,
  parameter int GPR_ID_WIDTH = WBU_GPR_ID_W
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_rst_n,
  input  logic                    i_sys_flush,
  input  logic                    i_lsu_valid,
  output logic                    o_wbu_ready,
  input  logic                    i_idu_ctr_reg_wr_en,
  input  logic [1:0]              i_idu_ctr_reg_wr_src,
  input  logic [GPR_ID_WIDTH-1:0] i_idu_gpr_wr_id,
  input  logic [DATA_WIDTH-1:0]   i_exu_res,
  input  logic [DATA_WIDTH-1:0]   i_lsu_gpr_wr_data,
  input  logic [ADDR_WIDTH-1:0]   i_ifu_pc,
  input  logic                    i_cmt_ready,
  output logic                    o_wbu_valid,
  output logic [ADDR_WIDTH-1:0]   o_wbu_pc,
  output logic                    o_wbu_gpr_wr_en,
  output logic [GPR_ID_WIDTH-1:0] o_wbu_gpr_wr_id,
  output logic [DATA_WIDTH-1:0]   o_wbu_gpr_wr_data,
  output logic                    o_wbu_fwd_valid,
  output logic [GPR_ID_WIDTH-1:0] o_wbu_fwd_id,
  output logic [DATA_WIDTH-1:0]   o_wbu_fwd_data,
  output logic [63:0]             o_wbu_retire_cnt
);

  // Same layout as wbu_entry_t, sized from this instance's parameters.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   pc;
    logic                    wr_en;
    logic [GPR_ID_WIDTH-1:0] wr_id;
    logic [DATA_WIDTH-1:0]   wr_data;
  } entry_t;

  entry_t                cap, head;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  valid, out;

  // PC+4 is formed at full result width so a PC near the top of the
  // address space carries into the upper bits instead of wrapping.
  always_comb begin
    sel_data = i_exu_res;
    case (i_idu_ctr_reg_wr_src)
      WR_SRC_LSU: sel_data = i_lsu_gpr_wr_data;
      WR_SRC_PC4: sel_data = DATA_WIDTH'(i_ifu_pc) + DATA_WIDTH'(4);
      default:    sel_data = i_exu_res;
    endcase
  end

  always_comb begin
    cap         = '0;
    cap.pc      = i_ifu_pc;
    cap.wr_en   = i_idu_ctr_reg_wr_en && (i_idu_gpr_wr_id != '0);  // x0 is never written
    cap.wr_id   = i_idu_gpr_wr_id;
    cap.wr_data = sel_data;
  end

  wbu_skid_buf #(.entry_t(entry_t)) u_buf (
    .clk     (i_sys_clk),
    .rst_n   (i_sys_rst_n),
    .flush   (i_sys_flush),
    .in_vld  (i_lsu_valid),
    .in_rdy  (o_wbu_ready),
    .in_data (cap),
    .out_vld (valid),
    .out_rdy (i_cmt_ready),
    .head    (head)
  );

  // The head register keeps stale contents after it drains, so every
  // head-derived output is masked by valid. Reset blocks the write strobe
  // in the cycle it is asserted.
  assign out               = valid && i_cmt_ready && i_sys_rst_n;
  assign o_wbu_valid       = valid;
  assign o_wbu_pc          = valid ? head.pc      : '0;
  assign o_wbu_gpr_wr_en   = out && head.wr_en;
  assign o_wbu_gpr_wr_id   = valid ? head.wr_id   : '0;
  assign o_wbu_gpr_wr_data = valid ? head.wr_data : '0;
  assign o_wbu_fwd_valid   = valid && head.wr_en;
  assign o_wbu_fwd_id      = valid ? head.wr_id   : '0;
  assign o_wbu_fwd_data    = valid ? head.wr_data : '0;

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n)  o_wbu_retire_cnt <= '0;
    else if (out)      o_wbu_retire_cnt <= o_wbu_retire_cnt + 64'd1;
  end

endmodule
